// File: rtl/riscv_types_pkg.sv
// Shared pipeline types for the core.
// Holds the IF/ID bundle and the fetch-queue entry layout.
package riscv_types;

  typedef struct packed {
    logic [31:0] current_pc;
    logic [31:0] pc_plus_4;
    logic [31:0] inst;
  } if_id_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Circular entry store for the fetch queue.
// Entries are allocated at grant, filled in order at response, popped at head.
module ifq_storage
  import riscv_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          alloc_i,
  input  logic [31:0]   alloc_pc_i,
  input  logic          fill_i,
  input  logic [31:0]   fill_inst_i,
  input  logic          pop_i,
  output ifq_entry_t    head_o,
  output logic [PW-1:0] count_o,
  output logic [PW-1:0] unfilled_o,
  output logic          full_o,
  output logic          empty_o
);

  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      head_d  = '0;
      alloc_d = '0;
      fill_d  = '0;
    end else begin
      if (alloc_i) begin
        mem_d[alloc_q[AW-1:0]] = '{
          pc: alloc_pc_i,
          inst: '0,
          filled: 1'b0
        };
        alloc_d = alloc_q + PW'(1);
      end
      if (fill_i) begin
        mem_d[fill_q[AW-1:0]].inst   = fill_inst_i;
        mem_d[fill_q[AW-1:0]].filled = 1'b1;
        fill_d = fill_q + PW'(1);
      end
      // a pop may retire the entry being filled this cycle
      if (pop_i) begin
        mem_d[head_q[AW-1:0]].filled = 1'b0;
        head_d = head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
    end
  end

  assign head_o     = mem_q[head_q[AW-1:0]];
  assign count_o    = alloc_q - head_q;
  assign unfilled_o = alloc_q - fill_q;
  assign full_o     = (count_o == PW'(DEPTH));
  assign empty_o    = (alloc_q == head_q);

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: PC, imem credits, redirect discard and IF/ID output.
// IFQ_RDATA_BYPASS_EN forwards a head response straight to decode.
module inst_fetch_queue
  import riscv_types::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int PW = $clog2(DEPTH) + 1,
  localparam int CW = PW + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output if_id_reg_t  if_id_o,
  input  logic        if_id_ready_i
);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] discard_q, discard_d;

  ifq_entry_t    head;
  logic [PW-1:0] count;
  logic [PW-1:0] unfilled;
  logic          full;
  logic          empty;

  logic [CW-1:0] credit_used;
  logic [PW-1:0] outstanding;
  logic          grant;
  logic          rsp_ok;
  logic          rsp_fill;
  logic          bypass;
  logic          pop;

  always_comb begin
    credit_used = {1'b0, count} + {1'b0, discard_q};
    outstanding = discard_q + unfilled;
    imem_req_o  = !reset && !redirect_i && !full
                  && (credit_used < CW'(DEPTH));
    imem_addr_o = fetch_pc_q;
    grant       = imem_req_o && imem_gnt_i;
    // a response with nothing outstanding is dropped
    rsp_ok      = imem_rvalid_i && (outstanding != '0);
    rsp_fill    = rsp_ok && (discard_q == '0);
`ifdef IFQ_RDATA_BYPASS_EN
    bypass      = rsp_fill && !empty && !head.filled;
`else
    bypass      = 1'b0;
`endif
    if_id_valid_o = !reset && !empty
                    && (head.filled || bypass);
    if_id_o = '0;
    if (if_id_valid_o) begin
      if_id_o.current_pc = head.pc;
      if_id_o.pc_plus_4  = head.pc + 32'd4;
`ifdef IFQ_RDATA_BYPASS_EN
      if_id_o.inst = head.filled ? head.inst
                                 : imem_rdata_i;
`else
      if_id_o.inst = head.inst;
`endif
    end
    pop = if_id_valid_o && if_id_ready_i;

    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'd3;
      discard_d  = outstanding - PW'(rsp_ok);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_ok && (discard_q != '0)) begin
        discard_d = discard_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  ifq_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect_i),
    .alloc_i    (grant),
    .alloc_pc_i (fetch_pc_q),
    .fill_i     (rsp_fill),
    .fill_inst_i(imem_rdata_i),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .unfilled_o (unfilled),
    .full_o     (full),
    .empty_o    (empty)
  );

endmodule
